// File: rtl/ca_pkg.sv
// Shared automaton / frame-buffer constants, reader FSM states and the
// word-to-row bit mapping used by both the row writer and the row reader.
package ca_pkg;

    localparam int ROW_W    = 8;
    localparam int COL_W    = 5;
    localparam int WORD_W   = 16;
    localparam int ROW_BITS = 512;
    localparam int ADDR_W   = ROW_W + COL_W;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } rd_state_t;

    // MSB index of the row slice held by buffer word `col`; word bit 15
    // lands on this bit.
    function automatic int base(input logic [COL_W-1:0] col);
        return ROW_BITS - 1 - WORD_W * int'(col);
    endfunction

endpackage

// File: rtl/buffer_row_reader.sv
// Reads the 32 words of one frame-buffer row and reassembles a 512-bit row.
// Ports: clk, reset (sync, active high), start/row_sel request, busy/done
// status, mem_addr/mem_rd/mem_data RAM port (1-cycle read), row_out result.
module buffer_row_reader
    import ca_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ROW_W-1:0]    row_sel,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_rd,
    input  logic [WORD_W-1:0]   mem_data,
    output logic [ROW_BITS-1:0] row_out
);

    localparam logic [COL_W-1:0] LAST_COL = '1;

    rd_state_t            state;
    logic [ROW_W-1:0]     row_q;
    logic [COL_W-1:0]     col_q;
    logic                 v_d;
    logic [COL_W-1:0]     col_d;
    logic [ROW_BITS-1:0]  shadow;
    logic [ROW_BITS-1:0]  shadow_nx;

    assign mem_addr = {row_q, col_q};

    // Merge the word arriving this cycle so the final word, which returns
    // during DRAIN, reaches row_out on the same edge.
    always_comb begin
        shadow_nx = shadow;
        if (v_d) begin
            shadow_nx[base(col_d) -: WORD_W] = mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            mem_rd  <= 1'b0;
            v_d     <= 1'b0;
            col_d   <= '0;
            shadow  <= '0;
            row_out <= '0;
        end else begin
            v_d    <= (state == READ);
            col_d  <= col_q;
            shadow <= shadow_nx;
            done   <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= READ;
                        row_q  <= row_sel;
                        col_q  <= '0;
                        busy   <= 1'b1;
                        mem_rd <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                READ: begin
                    // col_q parks on the last column; only a new start
                    // brings it back to zero.
                    if (col_q == LAST_COL) begin
                        state  <= DRAIN;
                        mem_rd <= 1'b0;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                DRAIN: begin
                    state   <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    row_out <= shadow_nx;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_row_reader.sv
// Self-checking bench for buffer_row_reader: one-cycle RAM model,
// phase-based behavioural reference, directed and random stimulus.
module tb_buffer_row_reader;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   row_sel = 8'h00;
    logic         busy;
    logic         done;
    logic [12:0]  mem_addr;
    logic         mem_rd;
    logic [15:0]  mem_data;
    logic [511:0] row_out;

    logic [15:0]  mem [0:8191];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    buffer_row_reader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .row_sel  (row_sel),
        .busy     (busy),
        .done     (done),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .row_out  (row_out)
    );

    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] assemble(input logic [7:0] r);
        logic [511:0] v;
        v = '0;
        for (int c = 0; c < 32; c++) begin
            v[511 - 16*c -: 16] = mem[{r, 5'(c)}];
        end
        return v;
    endfunction

    // Reference: ph counts cycles since an accepted start (1..32 READ,
    // 33 DRAIN, 34 DONE), 0 when idle.
    int           ph = 0;
    logic [7:0]   mrow = 8'h00;
    logic [511:0] exp_row = '0;
    bit           armed = 0;
    bit           m_rst = 0;

    always @(posedge clk) begin
        if (reset) begin
            armed = 1;
            m_rst = 1;
            ph = 0;
            exp_row = '0;
        end else begin
            m_rst = 0;
            if (ph >= 1 && ph <= 33) begin
                ph++;
                if (ph == 34) exp_row = assemble(mrow);
            end else if (start) begin
                ph = 1;
                mrow = row_sel;
            end else begin
                ph = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            logic e_rd;
            e_rd = (ph >= 1 && ph <= 32);
            chk("busy", 512'(busy), 512'(ph >= 1 && ph <= 33));
            chk("done", 512'(done), 512'(ph == 34));
            chk("mem_rd", 512'(mem_rd), 512'(e_rd));
            chk("row_out", row_out, exp_row);
            if (m_rst)
                chk("mem_addr_rst", 512'(mem_addr), 512'(0));
            else if (e_rd)
                chk("mem_addr", 512'(mem_addr),
                    512'({mrow, 5'(ph - 1)}));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] r);
        start = 1'b1;
        row_sel = r;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 1;
        while (!done && k < 40) begin
            tick();
            k++;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_done: no done within 40 cycles");
        end
    endtask

    logic [511:0] wr;
    int k;
    int nd;

    initial begin
        for (int a = 0; a < 8192; a++) begin
            mem[a] = {a[12:5], 3'b000, a[4:0]};
        end
        for (int i = 0; i < 16; i++) wr[32*i +: 32] = $urandom;
        for (int c = 0; c < 32; c++) begin
            mem[{8'hFF, 5'(c)}] = wr[511 - 16*c -: 16];
        end

        // reset with random inputs held
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            start = 1'($urandom);
            row_sel = 8'($urandom);
            tick();
            chk("rst_busy", 512'(busy), 512'(0));
            chk("rst_done", 512'(done), 512'(0));
            chk("rst_mem_rd", 512'(mem_rd), 512'(0));
            chk("rst_addr", 512'(mem_addr), 512'(0));
            chk("rst_row", row_out, 512'(0));
        end
        reset = 1'b0;
        start = 1'b0;
        tick();

        // read row 0x2A with literal latency pins
        launch(8'h2A);
        for (k = 1; k <= 34; k++) begin
            if (k == 1) chk("addr_c1", 512'(mem_addr), 512'(13'h540));
            if (k == 32) chk("addr_c32", 512'(mem_addr), 512'(13'h55F));
            chk($sformatf("done_c%0d", k), 512'(done), 512'(k == 34));
            if (k < 34) tick();
        end
        chk("row2a_hi", 512'(row_out[511:496]), 512'(16'h2A00));
        chk("row2a_lo", 512'(row_out[15:0]), 512'(16'h2A1F));
        tick();
        tick();

        // round trip row 255
        launch(8'hFF);
        wait_done(k);
        chk("rt_lat", 512'(k), 512'(34));
        chk("rt_row", row_out, wr);
        tick();

        // starts during READ ignored
        launch(8'h07);
        nd = 0;
        for (k = 1; k <= 40; k++) begin
            if (done) nd++;
            if (k == 5 || k == 20) begin
                start = 1'b1;
                row_sel = 8'h01;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        chk("ign_ndone", 512'(nd), 512'(1));
        chk("ign_row", 512'(row_out[511:496]), 512'(16'h0700));

        // back-to-back from DONE
        launch(8'h04);
        wait_done(k);
        chk("b2b_first", 512'(row_out[15:0]), 512'(16'h041F));
        launch(8'h03);
        wait_done(k);
        chk("b2b_lat", 512'(k), 512'(34));
        chk("b2b_row", 512'(row_out[511:496]), 512'(16'h0300));
        tick();

        // reset in cycle 10 of a read
        launch(8'h09);
        for (k = 1; k < 10; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 512'(busy), 512'(0));
        chk("abort_row", row_out, 512'(0));
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) nd++;
            tick();
        end
        chk("abort_ndone", 512'(nd), 512'(0));
        launch(8'h09);
        wait_done(k);
        chk("fresh_lat", 512'(k), 512'(34));
        chk("fresh_row", 512'(row_out[511:496]), 512'(16'h0900));
        tick();

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            row_sel = 8'($urandom);
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        start = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
